// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared image geometry, fetcher state encoding and 3x3 tap offsets
package cnn_pkg;
  localparam int IMG_W    = 28;
  localparam int IMG_H    = 28;
  localparam int K        = 3;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 10;
  localparam int NUM_TAPS = K * K;
  localparam int NUM_WIN  = (IMG_H - K + 1) * (IMG_W - K + 1);
  localparam int COORD_W  = 5;
  localparam int PAIR_W   = 3;

  // Taps are fetched two at a time; the fifth pair carries tap 8 alone.
  localparam logic [PAIR_W-1:0] LAST_PAIR = 3'd4;

  // Fetcher states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_OUT   = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Offset of tap t from the window's top-left address, tap 0 in the low slice.
  localparam logic [NUM_TAPS*ADDR_W-1:0] TAP_OFF = {
    ADDR_W'(2*IMG_W + 2), ADDR_W'(2*IMG_W + 1), ADDR_W'(2*IMG_W),
    ADDR_W'(IMG_W + 2),   ADDR_W'(IMG_W + 1),   ADDR_W'(IMG_W),
    ADDR_W'(2),           ADDR_W'(1),           ADDR_W'(0)
  };

  function automatic logic [ADDR_W-1:0] tap_off(input int t);
    return TAP_OFF[t*ADDR_W +: ADDR_W];
  endfunction
endpackage

// File: rtl/window_addr_gen.sv
// rtl/window_addr_gen.sv - window position tracker and per-pair tap address generator
module window_addr_gen
  import cnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_init,
  input  logic               i_advance,
  input  logic [PAIR_W-1:0]  i_pair,
  output logic [ADDR_W-1:0]  o_addr1,
  output logic [ADDR_W-1:0]  o_addr2,
  output logic [COORD_W-1:0] o_row,
  output logic [COORD_W-1:0] o_col,
  output logic               o_last
);
  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(IMG_W - K);
  localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(IMG_H - K);

  logic [COORD_W-1:0] r_row;
  logic [COORD_W-1:0] r_col;
  logic [ADDR_W-1:0]  r_row_base;
  logic [3:0]         w_tap_lo;
  logic [3:0]         w_tap_hi;

  // Row-major walk; row_base tracks row*IMG_W so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (!rst || i_init) begin
      r_row      <= '0;
      r_col      <= '0;
      r_row_base <= '0;
    end else if (i_advance) begin
      if (r_col == COL_MAX) begin
        r_col      <= '0;
        r_row      <= r_row + COORD_W'(1);
        r_row_base <= r_row_base + ADDR_W'(IMG_W);
      end else begin
        r_col <= r_col + COORD_W'(1);
      end
    end
  end

  // Pair p covers taps 2p and 2p+1; the last pair repeats tap 8 on both ports.
  always_comb begin
    w_tap_lo = {i_pair, 1'b0};
    w_tap_hi = w_tap_lo + 4'd1;
    if (i_pair >= LAST_PAIR) begin
      w_tap_lo = 4'(NUM_TAPS - 1);
      w_tap_hi = 4'(NUM_TAPS - 1);
    end
  end

  assign o_addr1 = r_row_base + ADDR_W'(r_col) + tap_off(int'(w_tap_lo));
  assign o_addr2 = r_row_base + ADDR_W'(r_col) + tap_off(int'(w_tap_hi));
  assign o_row   = r_row;
  assign o_col   = r_col;
  assign o_last  = (r_row == ROW_MAX) && (r_col == COL_MAX);
endmodule

// File: rtl/conv_window_fetcher.sv
// rtl/conv_window_fetcher.sv - streams every 3x3 window of the image memory to the conv engine
module conv_window_fetcher
  import cnn_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_mem_load,
  output logic [ADDR_W-1:0]          o_mem_addr1,
  output logic [ADDR_W-1:0]          o_mem_addr2,
  input  logic [DATA_W-1:0]          i_mem_data1,
  input  logic [DATA_W-1:0]          i_mem_data2,
  output logic                       o_win_valid,
  input  logic                       i_win_ready,
  output logic [NUM_TAPS*DATA_W-1:0] o_win_data,
  output logic [COORD_W-1:0]         o_win_row,
  output logic [COORD_W-1:0]         o_win_col,
  output logic                       o_win_last
);
  state_t                     r_state;
  logic [PAIR_W-1:0]          r_pair;
  logic [NUM_TAPS*DATA_W-1:0] r_win;
  logic [ADDR_W-1:0]          r_addr1_hold;
  logic [ADDR_W-1:0]          r_addr2_hold;

  logic              w_fetch;
  logic              w_out;
  logic              w_init;
  logic              w_hs;
  logic              w_last;
  logic              w_cap_en;
  logic [PAIR_W-1:0] w_cap_pair;
  logic [ADDR_W-1:0] w_addr1;
  logic [ADDR_W-1:0] w_addr2;

  assign w_fetch    = (r_state == ST_FETCH);
  assign w_out      = (r_state == ST_OUT);
  assign w_init     = (r_state == ST_IDLE) && i_start;
  assign w_hs       = w_out && i_win_ready;
  // Read data lags the issue by one cycle, so capture trails the pair counter.
  assign w_cap_en   = (w_fetch && (r_pair != '0)) || (r_state == ST_WAIT);
  assign w_cap_pair = w_fetch ? (r_pair - PAIR_W'(1)) : LAST_PAIR;

  window_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .i_init    (w_init),
    .i_advance (w_hs && !w_last),
    .i_pair    (r_pair),
    .o_addr1   (w_addr1),
    .o_addr2   (w_addr2),
    .o_row     (o_win_row),
    .o_col     (o_win_col),
    .o_last    (w_last)
  );

  // Sequence: five issue cycles, one drain cycle, then hold the window until accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_pair  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_FETCH;
            r_pair  <= '0;
          end
        end
        ST_FETCH: begin
          if (r_pair == LAST_PAIR) r_state <= ST_WAIT;
          else                     r_pair  <= r_pair + PAIR_W'(1);
        end
        ST_WAIT: r_state <= ST_OUT;
        ST_OUT: begin
          if (i_win_ready) begin
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_FETCH;
              r_pair  <= '0;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Drop returning pixels into their tap slots; port 2 of the last pair is a duplicate.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_win <= '0;
    end else if (w_cap_en) begin
      for (int q = 0; q < 4; q++) begin
        if (w_cap_pair == PAIR_W'(q)) begin
          r_win[DATA_W*(2*q) +: DATA_W]   <= i_mem_data1;
          r_win[DATA_W*(2*q+1) +: DATA_W] <= i_mem_data2;
        end
      end
      if (w_cap_pair == LAST_PAIR) r_win[DATA_W*(NUM_TAPS-1) +: DATA_W] <= i_mem_data1;
    end
  end

  // Remember the last issued addresses so the bus is quiet between fetches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr1_hold <= '0;
      r_addr2_hold <= '0;
    end else if (w_fetch) begin
      r_addr1_hold <= w_addr1;
      r_addr2_hold <= w_addr2;
    end
  end

  assign o_mem_load  = w_fetch;
  assign o_mem_addr1 = w_fetch ? w_addr1 : r_addr1_hold;
  assign o_mem_addr2 = w_fetch ? w_addr2 : r_addr2_hold;
  assign o_busy      = w_fetch || w_out || (r_state == ST_WAIT);
  assign o_done      = (r_state == ST_DONE);
  assign o_win_valid = w_out;
  assign o_win_last  = w_out && w_last;
  assign o_win_data  = r_win;
endmodule

// File: tb/tb_conv_window_fetcher.sv
// tb/tb_conv_window_fetcher.sv - randomized self-checking bench for conv_window_fetcher
module tb_conv_window_fetcher;
  import cnn_pkg::*;

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(IMG_W*IMG_H - 1);
  localparam int WIN_COLS = IMG_W - K + 1;

  logic clk = 1'b0;
  logic rst;
  logic i_start;
  logic i_win_ready;
  logic [DATA_W-1:0] i_mem_data1;
  logic [DATA_W-1:0] i_mem_data2;
  logic o_busy, o_done, o_mem_load, o_win_valid, o_win_last;
  logic [ADDR_W-1:0] o_mem_addr1, o_mem_addr2;
  logic [NUM_TAPS*DATA_W-1:0] o_win_data;
  logic [COORD_W-1:0] o_win_row, o_win_col;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit rand_mode = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int t0;
  bit prev_stall = 0;
  logic [NUM_TAPS*DATA_W-1:0] prev_data;
  logic [2*COORD_W-1:0] prev_pos;
  logic [2*ADDR_W-1:0] last_addr;
  logic [NUM_TAPS*DATA_W-1:0] w0;

  conv_window_fetcher dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_mem_load  (o_mem_load),
    .o_mem_addr1 (o_mem_addr1),
    .o_mem_addr2 (o_mem_addr2),
    .i_mem_data1 (i_mem_data1),
    .i_mem_data2 (i_mem_data2),
    .o_win_valid (o_win_valid),
    .i_win_ready (i_win_ready),
    .o_win_data  (o_win_data),
    .o_win_row   (o_win_row),
    .o_win_col   (o_win_col),
    .o_win_last  (o_win_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // image memory: each location holds the low byte of its own address, one-cycle read latency
  always @(posedge clk) begin
    if (o_mem_load) begin
      i_mem_data1 <= o_mem_addr1[7:0];
      i_mem_data2 <= o_mem_addr2[7:0];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // window n in row-major order: tap t = pixel (r + t/3, c + t%3)
  function automatic logic [NUM_TAPS*DATA_W-1:0] exp_win(input int n);
    int r;
    int c;
    logic [NUM_TAPS*DATA_W-1:0] w;
    r = n / WIN_COLS;
    c = n % WIN_COLS;
    for (int t = 0; t < NUM_TAPS; t++)
      w[DATA_W*t +: DATA_W] = 8'(((r + t/3) * IMG_W + c + t%3) & 255);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      i_win_ready = ($urandom_range(0, 3) != 0);
      i_start     = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!o_done && n < budget) begin
      tick();
      n++;
    end
    if (!o_done) chk("done_timeout", 128'(1), 128'(0));
    rand_mode = 0;
    i_start = 0;
    i_win_ready = 1;
    tick();
  endtask

  // monitor: scoreboard every handshake, stability under stall, address rules
  always @(negedge clk) begin
    if (rst) begin
      if (i_start && !o_busy && !o_done) begin
        hs_cnt = 0;
        done_cnt = 0;
        prev_stall = 0;
      end
      if (o_mem_load) begin
        chk("addr1_range", 128'(o_mem_addr1 > MAX_ADDR), 128'(0));
        chk("addr2_range", 128'(o_mem_addr2 > MAX_ADDR), 128'(0));
        chk("load_in_out", 128'(o_win_valid), 128'(0));
        last_addr = {o_mem_addr1, o_mem_addr2};
      end else begin
        chk("addr_hold", 128'({o_mem_addr1, o_mem_addr2}), 128'(last_addr));
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_win_valid) begin
        if (prev_stall) begin
          chk("hold_data", 128'(o_win_data), 128'(prev_data));
          chk("hold_pos", 128'({o_win_row, o_win_col}), 128'(prev_pos));
        end
        if (i_win_ready) begin
          chk("win_row", 128'(o_win_row), 128'(hs_cnt / WIN_COLS));
          chk("win_col", 128'(o_win_col), 128'(hs_cnt % WIN_COLS));
          chk("win_data", 128'(o_win_data), 128'(exp_win(hs_cnt)));
          chk("win_last", 128'(o_win_last), 128'(hs_cnt == NUM_WIN - 1));
          hs_cnt++;
        end
        prev_stall = !i_win_ready;
        prev_data = o_win_data;
        prev_pos = {o_win_row, o_win_col};
      end else begin
        prev_stall = 0;
      end
    end else begin
      prev_stall = 0;
      last_addr = '0;
    end
  end

  initial begin
    rst = 0;
    i_start = 0;
    i_win_ready = 0;
    w0 = {8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28, 8'd2, 8'd1, 8'd0};
    repeat (3) tick();
    chk("reset_outs", 128'({o_busy, o_done, o_mem_load, o_mem_addr1, o_mem_addr2, o_win_valid,
                            o_win_data, o_win_row, o_win_col, o_win_last}), 128'(0));
    rst = 1;
    tick();

    // full pass, consumer always ready, with cycle-exact timeline checks
    i_win_ready = 1;
    i_start = 1;
    t0 = cyc;
    tick();
    i_start = 0;
    chk("busy_c1", 128'(o_busy), 128'(1));
    chk("load_c1", 128'(o_mem_load), 128'(1));
    chk("addr_c1", 128'({o_mem_addr1, o_mem_addr2}), 128'({10'd0, 10'd1}));
    repeat (4) tick();
    chk("addr_c5", 128'({o_mem_addr1, o_mem_addr2}), 128'({10'd58, 10'd58}));
    tick();
    chk("valid_c6", 128'({o_win_valid, o_mem_load}), 128'(0));
    tick();
    chk("valid_c7", 128'(o_win_valid), 128'(1));
    chk("data_c7", 128'(o_win_data), 128'(w0));
    chk("pos_c7", 128'({o_win_row, o_win_col}), 128'(0));
    repeat (6) tick();
    chk("valid_c13", 128'(o_win_valid), 128'(0));
    tick();
    chk("valid_c14", 128'(o_win_valid), 128'(1));
    chk("pos_c14", 128'({o_win_row, o_win_col}), 128'({5'd0, 5'd1}));
    wait_done(6000);
    chk("done_cycle", 128'(done_cyc - t0), 128'(NUM_WIN * 7 + 1));
    chk("hs_count_a", 128'(hs_cnt), 128'(NUM_WIN));
    repeat (3) tick();
    chk("done_count_a", 128'(done_cnt), 128'(1));
    chk("idle_after_a", 128'({o_busy, o_done, o_win_valid, o_mem_load}), 128'(0));

    // random backpressure plus stray start pulses mid-pass
    i_start = 1;
    rand_mode = 1;
    tick();
    wait_done(10000);
    repeat (3) tick();
    chk("hs_count_b", 128'(hs_cnt), 128'(NUM_WIN));
    chk("done_count_b", 128'(done_cnt), 128'(1));
    chk("idle_after_b", 128'({o_busy, o_win_valid}), 128'(0));

    // reset while presenting window (10,5), then a clean restart
    i_win_ready = 1;
    i_start = 1;
    tick();
    i_start = 0;
    for (int n = 0; n < 3000 && !(o_win_valid && o_win_row == 5'd10 && o_win_col == 5'd5); n++) tick();
    chk("reach_10_5", 128'({o_win_valid, o_win_row, o_win_col}), 128'({1'b1, 5'd10, 5'd5}));
    rst = 0;
    i_win_ready = 0;
    tick();
    chk("abort_outs", 128'({o_busy, o_done, o_mem_load, o_mem_addr1, o_mem_addr2, o_win_valid,
                            o_win_data, o_win_row, o_win_col, o_win_last}), 128'(0));
    rst = 1;
    repeat (3) tick();
    chk("abort_no_done", 128'({done_cnt[0], o_busy, o_done}), 128'(0));
    i_win_ready = 1;
    i_start = 1;
    tick();
    i_start = 0;
    wait_done(6000);
    chk("hs_count_c", 128'(hs_cnt), 128'(NUM_WIN));
    chk("done_count_c", 128'(done_cnt), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/conv_window_fetcher.md
# conv_window_fetcher

Sequences the dual-port image memory to stream every 3x3 convolution window of a 28x28 8-bit image to the convolution engine. On `start` it walks all 26x26 valid window positions in row-major order and fetches each window's 9 pixels two per cycle through the memory's two read ports. It assembles each window in a register and presents it on a valid/ready interface. It sits between the image memory and the first conv layer and is the only master of the memory's `load`/`addr1`/`addr2` inputs.

## Interface
- `IMG_W`, 28, image width in pixels
- `IMG_H`, 28, image height in pixels
- `K`, 3, kernel size (window is KxK)
- `DATA_W`, 8, pixel width
- `ADDR_W`, 10, memory address width (must hold IMG_W*IMG_H-1)
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a full image pass; ignored while `busy`
- `busy`  out  1  high from the cycle after an accepted `start` until the `done` pulse
- `done`  out  1  one-cycle pulse after the last window handshake
- `mem_load`  out  1  memory read enable
- `mem_addr1`, `mem_addr2`  out  ADDR_W  memory read addresses
- `mem_data1`, `mem_data2`  in  DATA_W  memory read data, valid one cycle after `mem_load`
- `win_valid`  out  1  window available
- `win_ready`  in  1  consumer accepts the window
- `win_data`  out  K*K*DATA_W  tap t (t = 3*r + c) at bits [DATA_W*t +: DATA_W], raw bits, no sign handling
- `win_row`, `win_col`  out  5  top-left coordinate of the current window
- `win_last`  out  1  high with `win_valid` for window (IMG_H-K, IMG_W-K)

## Operation
- States: IDLE, FETCH, WAIT, OUT, DONE.
- IDLE: if `start`, set row=col=0 and row_base=0, then go to FETCH.
- FETCH: 5 issue cycles, p = 0..4, with `mem_load`=1.
  - Tap pairs: (0,1), (2,3), (4,5), (6,7), (8,8). Port 1 gets the lower tap, port 2 the higher.
  - Tap address = row_base + col + (t/3)*IMG_W + t%3.
  - The tap offsets are constants {0, 1, 2, W, W+1, W+2, 2W, 2W+1, 2W+2}. No multiplier.
  - Data captured in cycle p+1 goes into taps of pair p. Port 2 data for pair 4 is discarded.
  - After p=4, go to WAIT.
- WAIT: `mem_load`=0; capture pair 4, then go to OUT.
- OUT: `win_valid`=1.
  - `win_data`, `win_row`, `win_col` and `win_last` stay stable until `win_ready`.
  - On handshake, if `win_last` go to DONE. Otherwise advance the position and go to FETCH.
  - Advance: col+1; at col=IMG_W-K, set col=0, row+1, row_base+=IMG_W.
- DONE: `done`=1 for one cycle, then IDLE.
- `mem_load`=0 outside FETCH. Addresses hold their last value when not loading.
- `start` in any state other than IDLE has no effect.
- The window register is never read by the consumer outside OUT.

## Timing
- Reset values: state IDLE, all outputs 0 (`win_data`, addresses, flags, coordinates), row/col/row_base 0.
- Reset asserted mid-pass aborts immediately. No `done` pulse; the next `start` restarts from (0,0).
- Timeline from `start` accepted in cycle 0:
  - FETCH cycles 1–5
  - WAIT cycle 6
  - first `win_valid` in cycle 7
- With `win_ready` held high, throughput is 1 window per 7 cycles. A full pass is 676 windows.
- `done` asserts the cycle after the final handshake; `busy` drops in the same cycle.
- Handshake occurs on a cycle with `win_valid` && `win_ready`. `win_ready` high outside OUT is ignored.
- Final window (25,25): top-left address 725, last tap address 783 = IMG_W*IMG_H-1. No address may exceed 783.

## Structure
- Shared package `cnn_pkg`:
  - IMG_W, IMG_H, K, DATA_W, ADDR_W
  - state enum
  - tap offset constant array
  - NUM_WIN = (IMG_H-K+1)*(IMG_W-K+1)
- Sub-module `window_addr_gen`: holds row/col/row_base and the advance logic. Outputs the two tap addresses for a given pair index, plus the last-position flag.
- The FSM and tap capture register stay in the top module.

## Test plan
All scenarios use a memory model with 1-cycle latency and mem[a] = a[7:0].
- Reset, then `start` with `win_ready`=1 -> first window (0,0) shows taps {0,1,2,28,29,30,56,57,58} at cycle 7; next `win_valid` 7 cycles later at (0,1).
- Full pass with `win_ready`=1 -> exactly 676 handshakes, row-major order, single `done` at cycle 676*7+1. The window at (0,25) is followed by (1,0), whose tap 0 is 28.
- Random `win_ready` backpressure -> `win_data` and coordinates stable while valid && !ready. No `mem_load` during OUT. Window contents still match the model.
- `start` pulsed during FETCH and OUT -> ignored; the pass completes normally with a single `done`.
- `rst`=0 asserted while in OUT at window (10,5) -> next cycle all outputs 0, state IDLE. A new `start` yields window (0,0) first.
- Last window -> `win_last`=1 only at (25,25), taps end at 783 (low byte 0x0F). `mem_addr1`/`mem_addr2` never exceed 783 across the whole pass.
